// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (req0)
// and the branch/compare unit (req1). Optional macro: ALU_FAST_ISSUE_EN (issue during RESP handshake).
package alu_pkg;
    typedef enum logic [3:0] {
        ADD, SUB, XORL, ORL, ANDL, SLL, SRL, SRA,
        SLTS, SLTU, EQ, NE, LTS, LTU, GES, GEU
    } operator_t;
endpackage

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter bit          RESET_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  operator_t       req0_op,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  operator_t       req1_op,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,
    output logic [2:0]      rsp0_flags,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,
    output logic [2:0]      rsp1_flags,

    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output operator_t       alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_lt,
    input  logic            alu_ltu,
    input  logic            alu_zeros,

    output logic            busy,
    output logic            grant_id
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    operator_t       op_q;
    logic            grant_q;
    logic            last_q;
    logic [XLEN-1:0] result_q;
    logic [2:0]      flags_q;

    logic rsp_hs;
    logic can_issue;
    logic arb_last;
    logic sel;
    logic issue;

    always_comb begin
        rsp_hs = (state == RESP) && (grant_q ? rsp1_ready : rsp0_ready);
`ifdef ALU_FAST_ISSUE_EN
        // During the response handshake the outgoing grant acts as the round-robin pointer.
        can_issue = (state == IDLE) || rsp_hs;
        arb_last  = (state == RESP) ? grant_q : last_q;
`else
        can_issue = (state == IDLE);
        arb_last  = last_q;
`endif
        sel        = (req0_valid && req1_valid) ? ~arb_last : req1_valid;
        issue      = rst_n && can_issue && (req0_valid || req1_valid);
        req0_ready = issue && !sel;
        req1_ready = issue && sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= ADD;
            grant_q  <= RESET_PRIO;
            last_q   <= ~RESET_PRIO;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        a_q     <= sel ? req1_a  : req0_a;
                        b_q     <= sel ? req1_b  : req0_b;
                        op_q    <= sel ? req1_op : req0_op;
                        grant_q <= sel;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= alu_result;
                    flags_q  <= {alu_zeros, alu_lt, alu_ltu};
                    state    <= RESP;
                end
                RESP: begin
                    // issue can only be set here when fast issue is compiled in
                    if (rsp_hs) begin
                        last_q <= grant_q;
                        state  <= IDLE;
                        if (issue) begin
                            a_q     <= sel ? req1_a  : req0_a;
                            b_q     <= sel ? req1_b  : req0_b;
                            op_q    <= sel ? req1_op : req0_op;
                            grant_q <= sel;
                            state   <= EXEC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign rsp0_valid  = (state == RESP) && !grant_q;
    assign rsp1_valid  = (state == RESP) && grant_q;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_flags  = flags_q;
    assign rsp1_flags  = flags_q;
    assign busy        = (state != IDLE);
    assign grant_id    = grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU on the alu_* ports.
// Expected values are hand-computed constants.
module tb_alu_arbiter;
    import alu_pkg::*;

`ifdef ALU_FAST_ISSUE_EN
    localparam int  EXP_GAP = 2;
    localparam logic FAST   = 1'b1;
`else
    localparam int  EXP_GAP = 3;
    localparam logic FAST   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    operator_t   req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic [2:0]  rsp0_flags, rsp1_flags;
    logic [31:0] alu_a, alu_b, alu_result;
    operator_t   alu_op;
    logic        alu_lt, alu_ltu, alu_zeros;
    logic        busy, grant_id;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(32), .RESET_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .alu_lt(alu_lt), .alu_ltu(alu_ltu), .alu_zeros(alu_zeros),
        .busy(busy), .grant_id(grant_id)
    );

    // Comparison flags only report for compare ops; zeros always reflects the result.
    always_comb begin
        logic cmp;
        cmp        = 1'b0;
        alu_result = '0;
        case (alu_op)
            ADD:  alu_result = alu_a + alu_b;
            SUB:  alu_result = alu_a - alu_b;
            XORL: alu_result = alu_a ^ alu_b;
            ORL:  alu_result = alu_a | alu_b;
            ANDL: alu_result = alu_a & alu_b;
            SLL:  alu_result = alu_a << alu_b[4:0];
            SRL:  alu_result = alu_a >> alu_b[4:0];
            SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            SLTS, LTS: begin cmp = 1'b1; alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)}; end
            SLTU, LTU: begin cmp = 1'b1; alu_result = {31'd0, alu_a < alu_b}; end
            EQ:   begin cmp = 1'b1; alu_result = {31'd0, alu_a == alu_b}; end
            NE:   begin cmp = 1'b1; alu_result = {31'd0, alu_a != alu_b}; end
            GES:  begin cmp = 1'b1; alu_result = {31'd0, $signed(alu_a) >= $signed(alu_b)}; end
            GEU:  begin cmp = 1'b1; alu_result = {31'd0, alu_a >= alu_b}; end
            default: alu_result = '0;
        endcase
        alu_lt    = cmp && ($signed(alu_a) < $signed(alu_b));
        alu_ltu   = cmp && (alu_a < alu_b);
        alu_zeros = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b, input operator_t op,
                          input logic [31:0] er, input logic [2:0] ef, input string tag);
        int k;
        if (id) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
        #1;
        k = 0;
        while (!(id ? req1_ready : req0_ready) && k < 20) begin tick; k++; end
        check({tag, "_ready"}, 64'(id ? req1_ready : req0_ready), 64'd1);
        tick;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        k = 0;
        while (!(id ? rsp1_valid : rsp0_valid) && k < 20) begin tick; k++; end
        check({tag, "_lat"}, 64'(k), 64'd1);
        check({tag, "_res"}, 64'(id ? rsp1_result : rsp0_result), 64'(er));
        check({tag, "_flg"}, 64'(id ? rsp1_flags : rsp0_flags), 64'(ef));
        check({tag, "_other"}, 64'(id ? rsp0_valid : rsp1_valid), 64'd0);
        if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        tick;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants[4];
        int ng, nr, nh;
        int rid[2];
        logic [31:0] rres[2];
        logic [2:0]  rflg[2];
        int hs_cyc[4];

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd9; req0_op = SUB;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = ADD;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tick;
        tick;
        // Reset state, with a request pending to prove ready is held low.
        check("rst_ready0", 64'(req0_ready), 64'd0);
        check("rst_ready1", 64'(req1_ready), 64'd0);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_rspv",   64'({rsp0_valid, rsp1_valid}), 64'd0);
        check("rst_res",    64'(rsp0_result), 64'd0);
        check("rst_flg",    64'(rsp1_flags), 64'd0);
        check("rst_alu_a",  64'(alu_a), 64'd0);
        check("rst_alu_b",  64'(alu_b), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'(ADD));
        check("rst_grant",  64'(grant_id), 64'd0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        tick;

        // Single request with explicit staging checks.
        req0_a = 32'd10; req0_b = 32'd20; req0_op = ADD; req0_valid = 1'b1;
        #1;
        check("single_ready0", 64'(req0_ready), 64'd1);
        check("single_ready1", 64'(req1_ready), 64'd0);
        tick;
        req0_valid = 1'b0;
        check("single_exec_busy",  64'(busy), 64'd1);
        check("single_exec_rspv",  64'(rsp0_valid), 64'd0);
        check("single_exec_alu_a", 64'(alu_a), 64'd10);
        check("single_exec_alu_b", 64'(alu_b), 64'd20);
        tick;
        check("single_rspv0", 64'(rsp0_valid), 64'd1);
        check("single_rspv1", 64'(rsp1_valid), 64'd0);
        check("single_res",   64'(rsp0_result), 64'd30);
        check("single_flg",   64'(rsp0_flags), 64'd0);
        rsp0_ready = 1'b1;
        tick;
        rsp0_ready = 1'b0;
        check("single_done", 64'(busy), 64'd0);

        // Simultaneous requests held continuously: RESET_PRIO wins first, then alternation.
        pulse_reset;
        req0_a = 32'd20; req0_b = 32'd10; req0_op = SUB;
        req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_op = SLTS;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        ng = 0; nr = 0;
        grants = '{default: 2};
        rid = '{default: 2};
        for (int c = 0; c < 20; c++) begin
            if (req0_ready && ng < 4) begin grants[ng] = 0; ng++; end
            if (req1_ready && ng < 4) begin grants[ng] = 1; ng++; end
            if (rsp0_valid && nr < 2) begin rid[nr] = 0; rres[nr] = rsp0_result; rflg[nr] = rsp0_flags; nr++; end
            if (rsp1_valid && nr < 2) begin rid[nr] = 1; rres[nr] = rsp1_result; rflg[nr] = rsp1_flags; nr++; end
            tick;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) tick;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        check("alt_ngrants", 64'(ng), 64'd4);
        for (int i = 0; i < 4; i++) check($sformatf("alt_grant%0d", i), 64'(grants[i]), 64'(i % 2));
        check("alt_nrsp", 64'(nr), 64'd2);
        check("sim_first_id",   64'(rid[0]), 64'd0);
        check("sim_first_res",  64'(rres[0]), 64'd10);
        check("sim_first_flg",  64'(rflg[0]), 64'b000);
        check("sim_second_id",  64'(rid[1]), 64'd1);
        check("sim_second_res", 64'(rres[1]), 64'd1);
        check("sim_second_flg", 64'(rflg[1]), 64'b010);

        // Backpressure on req1 with a competing req0 pending.
        pulse_reset;
        req1_a = 32'hA5A5_A5A5; req1_b = 32'h0F0F_0F0F; req1_op = XORL; req1_valid = 1'b1;
        #1;
        check("bp_ready1", 64'(req1_ready), 64'd1);
        tick;
        req1_valid = 1'b0;
        req0_a = 32'd7; req0_b = 32'd8; req0_op = ADD; req0_valid = 1'b1;
        tick;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_rspv_%0d", c), 64'(rsp1_valid), 64'd1);
            check($sformatf("bp_res_%0d", c),  64'(rsp1_result), 64'hAAAA_AAAA);
            check($sformatf("bp_rdy_%0d", c),  64'({req0_ready, req1_ready}), 64'd0);
            tick;
        end
        rsp1_ready = 1'b1;
        #1;
        check("bp_hs_flg",    64'(rsp1_flags), 64'b000);
        check("bp_hs_ready0", 64'(req0_ready), 64'(FAST));
        tick;
        rsp1_ready = 1'b0;
`ifndef ALU_FAST_ISSUE_EN
        check("bp_idle_ready0", 64'(req0_ready), 64'd1);
        tick;
`endif
        req0_valid = 1'b0;
        check("bp_next_grant", 64'(grant_id), 64'd0);
        tick;
        check("bp_next_rspv", 64'(rsp0_valid), 64'd1);
        check("bp_next_res",  64'(rsp0_result), 64'd15);
        rsp0_ready = 1'b1;
        tick;
        rsp0_ready = 1'b0;

        // Reset while in EXEC aborts the operation.
        req0_a = 32'd5; req0_b = 32'd6; req0_op = SUB; req0_valid = 1'b1;
        #1;
        tick;
        req0_valid = 1'b0;
        check("mid_busy_exec", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_busy",   64'(busy), 64'd0);
        check("mid_rspv",   64'({rsp0_valid, rsp1_valid}), 64'd0);
        check("mid_alu_a",  64'(alu_a), 64'd0);
        check("mid_alu_op", 64'(alu_op), 64'(ADD));
        check("mid_res",    64'(rsp0_result), 64'd0);
        tick;
        rst_n = 1'b1;
        repeat (3) begin
            tick;
            check("mid_no_rsp", 64'({rsp0_valid, rsp1_valid, busy}), 64'd0);
        end
        run_op(1'b0, 32'd1, 32'd1, ADD, 32'd2, 3'b000, "mid_add");

        // Flag capture through the EXEC register stage.
        run_op(1'b0, 32'd2, 32'hFFFF_FFFD, GEU, 32'd0, 3'b101, "flg_geu");
        run_op(1'b0, 32'd1, 32'd1, EQ, 32'd1, 3'b000, "flg_eq");
        run_op(1'b1, 32'd3, 32'd3, NE, 32'd0, 3'b100, "flg_ne");

        // Back-to-back req0 stream throughput.
        pulse_reset;
        req0_a = 32'd3; req0_b = 32'd4; req0_op = ADD; req0_valid = 1'b1;
        rsp0_ready = 1'b1;
        #1;
        nh = 0;
        hs_cyc = '{default: 0};
        for (int c = 0; c < 30; c++) begin
            if (rsp0_valid && nh < 4) begin hs_cyc[nh] = c; nh++; end
            tick;
        end
        req0_valid = 1'b0;
        repeat (4) tick;
        rsp0_ready = 1'b0;
        check("tp_count", 64'(nh), 64'd4);
        for (int i = 1; i < 4; i++)
            check($sformatf("tp_gap%0d", i), 64'(hs_cyc[i] - hs_cyc[i-1]), 64'(EXP_GAP));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
